// File: rtl/qam_burst_sequencer.sv
// Burst timing/framing controller for the 16-QAM modulator: carrier/symbol strobes, ROM phase, I/Q symbol packing.
// Latency: strobes are combinational from the counters; SigI/SigQ/sym_valid appear the cycle after the symbol strobe.
// Backpressure: bit_ready drops once 4 bits are held and rises again when a payload symbol consumes them.
module qam_burst_sequencer #(
    parameter int CARRIER_DIV     = 2,
    parameter int SAMPLES_PER_SYM = 8,
    parameter int PHASE_W         = 5,
    parameter int PHASE_STEP      = 4,
    parameter int PREAMBLE_SYMS   = 4,
    parameter int BURST_SYMS      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic               busy,
    output logic               clk_CarryWave,
    output logic               clk_level,
    output logic [PHASE_W-1:0] rom_addr,
    output logic               m_align,
    output logic [1:0]         SigI,
    output logic [1:0]         SigQ,
    output logic               sym_valid,
    output logic               underrun,
    output logic               done
);

    localparam int DIV_W   = $clog2(CARRIER_DIV);
    localparam int SAMP_W  = $clog2(SAMPLES_PER_SYM);
    localparam int SYM_MAX = (PREAMBLE_SYMS > BURST_SYMS) ? PREAMBLE_SYMS : BURST_SYMS;
    localparam int SYM_W   = $clog2(SYM_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
    logic [SYM_W-1:0]     sym_cnt_q, sym_cnt_d;
    logic [PHASE_W-1:0]   rom_addr_q, rom_addr_d;
    logic [3:0]           shreg_q, shreg_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           sig_i_q, sig_i_d;
    logic [1:0]           sig_q_q, sig_q_d;
    logic                 sym_valid_q, sym_valid_d;
    logic                 accept;

    assign busy          = (state_q != IDLE);
    assign bit_ready     = ((state_q == PREAMBLE) || (state_q == PAYLOAD)) && (bit_cnt_q < 3'd4);
    assign accept        = bit_valid && bit_ready;
    assign clk_CarryWave = busy && (div_cnt_q == DIV_W'(CARRIER_DIV - 1));
    assign clk_level     = clk_CarryWave && (samp_cnt_q == SAMP_W'(SAMPLES_PER_SYM - 1));
    assign rom_addr      = rom_addr_q;
    assign SigI          = sig_i_q;
    assign SigQ          = sig_q_q;
    assign sym_valid     = sym_valid_q;

    // Next-state: strobe counters, bit collector, burst phase sequencing and symbol loads.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        rom_addr_d  = rom_addr_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        sig_i_d     = sig_i_q;
        sig_q_d     = sig_q_q;
        sym_valid_d = sym_valid_q;
        m_align     = 1'b0;
        underrun    = 1'b0;
        done        = 1'b0;

        if (busy) begin
            div_cnt_d = (div_cnt_q == DIV_W'(CARRIER_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        end
        if (clk_CarryWave) begin
            rom_addr_d = rom_addr_q + PHASE_W'(PHASE_STEP);
            samp_cnt_d = (samp_cnt_q == SAMP_W'(SAMPLES_PER_SYM - 1)) ? '0 : samp_cnt_q + 1'b1;
        end
        if (accept) begin
            shreg_d   = {shreg_q[2:0], bit_in};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PREAMBLE;
                    div_cnt_d   = '0;
                    samp_cnt_d  = '0;
                    sym_cnt_d   = '0;
                    rom_addr_d  = '0;
                    shreg_d     = '0;
                    bit_cnt_d   = '0;
                    sig_i_d     = 2'b00;
                    sig_q_d     = 2'b00;
                    sym_valid_d = 1'b0;
                end
            end
            PREAMBLE: begin
                if (clk_level) begin
                    // Alternating 00/11 training pattern, starting with 00.
                    sig_i_d     = sym_cnt_q[0] ? 2'b11 : 2'b00;
                    sig_q_d     = sym_cnt_q[0] ? 2'b11 : 2'b00;
                    sym_valid_d = 1'b1;
                    if (sym_cnt_q == SYM_W'(PREAMBLE_SYMS - 1)) begin
                        state_d   = PAYLOAD;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (clk_level) begin
                    m_align     = (sym_cnt_q == '0);
                    sym_valid_d = 1'b1;
                    if (bit_cnt_q == 3'd4) begin
                        sig_i_d = shreg_q[3:2];
                        sig_q_d = shreg_q[1:0];
                    end else begin
                        // Short collector: send a zero symbol and drop the partial bits.
                        sig_i_d  = 2'b00;
                        sig_q_d  = 2'b00;
                        underrun = 1'b1;
                    end
                    // A bit accepted on the load edge starts the next collector.
                    shreg_d   = accept ? {3'b000, bit_in} : 4'b0000;
                    bit_cnt_d = accept ? 3'd1 : 3'd0;
                    if (sym_cnt_q == SYM_W'(BURST_SYMS - 1)) begin
                        state_d   = FLUSH;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (clk_level) begin
                    if (sym_cnt_q == '0) begin
                        sig_i_d     = 2'b00;
                        sig_q_d     = 2'b00;
                        sym_valid_d = 1'b0;
                        sym_cnt_d   = sym_cnt_q + 1'b1;
                    end else begin
                        done      = 1'b1;
                        state_d   = IDLE;
                        sym_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset returns everything to idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            samp_cnt_q  <= '0;
            sym_cnt_q   <= '0;
            rom_addr_q  <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sig_i_q     <= '0;
            sig_q_q     <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            rom_addr_q  <= rom_addr_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            sig_i_q     <= sig_i_d;
            sig_q_q     <= sig_q_d;
            sym_valid_q <= sym_valid_d;
        end
    end

endmodule

// File: tb/tb_qam_burst_sequencer.sv
// Directed bench for qam_burst_sequencer with default parameters.
// Cycle k is observed and driven at the falling edge; start is sampled at the rising edge ending cycle 0.
// Symbol strobe k = 16*L, symbol loaded at level L visible from k = 16*L+1; burst ends at level 22.
module tb_qam_burst_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready, busy, clk_CarryWave, clk_level, m_align;
    logic [4:0] rom_addr;
    logic [1:0] SigI, SigQ;
    logic       sym_valid, underrun, done;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;
    bit bitq[$];

    qam_burst_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .busy(busy), .clk_CarryWave(clk_CarryWave), .clk_level(clk_level),
        .rom_addr(rom_addr), .m_align(m_align), .SigI(SigI), .SigQ(SigQ), .sym_valid(sym_valid),
        .underrun(underrun), .done(done)
    );

    always #5 clk = ~clk;

    // Advance one cycle; start is a one-cycle pulse; bits are offered from the queue.
    task automatic step();
        @(negedge clk);
        k++;
        start = 1'b0;
        if (bitq.size() > 0) begin
            bit_valid = 1'b1;
            bit_in    = bitq[0];
            if (bit_ready) void'(bitq.pop_front());
        end else begin
            bit_valid = 1'b0;
            bit_in    = 1'b0;
        end
    endtask

    task automatic push_nibble(input logic [3:0] n);
        for (int i = 3; i >= 0; i--) bitq.push_back(n[i]);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if ({busy, bit_ready, clk_CarryWave, clk_level, m_align, sym_valid, underrun, done} !== 8'h00) begin miscompares++; $display("FAIL reset_flags got=%b exp=00000000", {busy, bit_ready, clk_CarryWave, clk_level, m_align, sym_valid, underrun, done}); end
        vectors++; if ({rom_addr, SigI, SigQ} !== 9'h000) begin miscompares++; $display("FAIL reset_data got=%h exp=000", {rom_addr, SigI, SigQ}); end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++; if ({busy, bit_ready, clk_CarryWave, clk_level, done} !== 5'b00000) begin miscompares++; $display("FAIL idle_quiet k=%0d got=%b exp=00000", k, {busy, bit_ready, clk_CarryWave, clk_level, done}); end
        end
    endtask

    task automatic test_strobes_preamble();
        logic [4:0] exp_rom;
        logic [1:0] exp_sig;
        @(negedge clk);
        k = 0;
        start = 1'b1;
        repeat (3) push_nibble(4'b1001);
        for (int i = 0; i < 80; i++) begin
            step();
            exp_rom = 5'((((k - 1) / 2) * 4) % 32);
            vectors++; if (clk_CarryWave !== (k % 2 == 0)) begin miscompares++; $display("FAIL carrier_strobe k=%0d got=%b exp=%b", k, clk_CarryWave, (k % 2 == 0)); end
            vectors++; if (clk_level !== (k % 16 == 0)) begin miscompares++; $display("FAIL symbol_strobe k=%0d got=%b exp=%b", k, clk_level, (k % 16 == 0)); end
            vectors++; if (rom_addr !== exp_rom) begin miscompares++; $display("FAIL rom_addr k=%0d got=%0d exp=%0d", k, rom_addr, exp_rom); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_pre k=%0d got=%b exp=1", k, busy); end
            vectors++; if (m_align !== (k == 80)) begin miscompares++; $display("FAIL m_align k=%0d got=%b exp=%b", k, m_align, (k == 80)); end
            if (k == 16) begin
                vectors++; if (sym_valid !== 1'b0) begin miscompares++; $display("FAIL sym_valid_early k=%0d got=%b exp=0", k, sym_valid); end
            end
            if (k == 17 || k == 33 || k == 49 || k == 65) begin
                exp_sig = (((k - 1) / 16 - 1) % 2 == 1) ? 2'b11 : 2'b00;
                vectors++; if ({SigI, SigQ, sym_valid} !== {exp_sig, exp_sig, 1'b1}) begin miscompares++; $display("FAIL preamble_sym k=%0d got=%b exp=%b", k, {SigI, SigQ, sym_valid}, {exp_sig, exp_sig, 1'b1}); end
            end
            if (k == 1) begin
                vectors++; if (bit_ready !== 1'b1) begin miscompares++; $display("FAIL ready_empty k=%0d got=%b exp=1", k, bit_ready); end
            end
            if (k == 10 || k == 80) begin
                vectors++; if (bit_ready !== 1'b0) begin miscompares++; $display("FAIL ready_full k=%0d got=%b exp=0", k, bit_ready); end
            end
        end
    endtask

    task automatic test_payload_underrun();
        int L;
        logic [1:0] exp_i, exp_q;
        for (int i = 0; i < 256; i++) begin
            step();
            vectors++; if ({clk_CarryWave, clk_level} !== {(k % 2 == 0), (k % 16 == 0)}) begin miscompares++; $display("FAIL strobes_pay k=%0d got=%b exp=%b", k, {clk_CarryWave, clk_level}, {(k % 2 == 0), (k % 16 == 0)}); end
            vectors++; if (underrun !== (k == 128)) begin miscompares++; $display("FAIL underrun k=%0d got=%b exp=%b", k, underrun, (k == 128)); end
            vectors++; if ({busy, m_align} !== 2'b10) begin miscompares++; $display("FAIL busy_align_pay k=%0d got=%b exp=10", k, {busy, m_align}); end
            L = (k - 1) / 16;
            if (k % 16 == 1) begin
                if (L - 5 == 3) begin exp_i = 2'b00; exp_q = 2'b00; end
                else if (L - 5 == 4) begin exp_i = 2'b01; exp_q = 2'b10; end
                else begin exp_i = 2'b10; exp_q = 2'b01; end
                vectors++; if ({SigI, SigQ, sym_valid} !== {exp_i, exp_q, 1'b1}) begin miscompares++; $display("FAIL payload_sym k=%0d got=%b exp=%b", k, {SigI, SigQ, sym_valid}, {exp_i, exp_q, 1'b1}); end
                if (L <= 19) begin
                    vectors++; if (bit_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_load k=%0d got=%b exp=1", k, bit_ready); end
                end
            end
            if (k % 16 == 0) begin
                vectors++; if (bit_ready !== (k == 128)) begin miscompares++; $display("FAIL ready_before_load k=%0d got=%b exp=%b", k, bit_ready, (k == 128)); end
            end
            if (k == 112) begin bitq.push_back(1'b1); bitq.push_back(1'b1); end
            if (k == 128) begin
                push_nibble(4'b0110);
                repeat (11) push_nibble(4'b1001);
            end
            if (k == 200) start = 1'b1;
        end
    endtask

    task automatic test_flush_done();
        int kk;
        logic [4:0] exp_rom;
        for (int i = 0; i < 26; i++) begin
            step();
            kk = (k < 353) ? k : 353;
            exp_rom = 5'((((kk - 1) / 2) * 4) % 32);
            vectors++; if ({SigI, SigQ, sym_valid, bit_ready} !== 6'b000000) begin miscompares++; $display("FAIL flush_sym k=%0d got=%b exp=000000", k, {SigI, SigQ, sym_valid, bit_ready}); end
            vectors++; if (done !== (k == 352)) begin miscompares++; $display("FAIL done k=%0d got=%b exp=%b", k, done, (k == 352)); end
            vectors++; if (busy !== (k <= 352)) begin miscompares++; $display("FAIL busy_end k=%0d got=%b exp=%b", k, busy, (k <= 352)); end
            vectors++; if (clk_CarryWave !== (k <= 352 && k % 2 == 0)) begin miscompares++; $display("FAIL carrier_end k=%0d got=%b exp=%b", k, clk_CarryWave, (k <= 352 && k % 2 == 0)); end
            vectors++; if (clk_level !== (k == 352)) begin miscompares++; $display("FAIL level_end k=%0d got=%b exp=%b", k, clk_level, (k == 352)); end
            vectors++; if (rom_addr !== exp_rom) begin miscompares++; $display("FAIL rom_hold k=%0d got=%0d exp=%0d", k, rom_addr, exp_rom); end
            if (k == 352) start = 1'b1;
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        k = 0;
        start = 1'b1;
        repeat (6) push_nibble(4'b1001);
        repeat (150) step();
        vectors++; if ({busy, sym_valid} !== 2'b11) begin miscompares++; $display("FAIL mid_busy k=%0d got=%b exp=11", k, {busy, sym_valid}); end
        #2 rst = 1'b0;
        #1;
        vectors++; if ({busy, bit_ready, clk_CarryWave, clk_level, m_align, sym_valid, underrun, done} !== 8'h00) begin miscompares++; $display("FAIL arst_flags got=%b exp=00000000", {busy, bit_ready, clk_CarryWave, clk_level, m_align, sym_valid, underrun, done}); end
        vectors++; if ({rom_addr, SigI, SigQ} !== 9'h000) begin miscompares++; $display("FAIL arst_data got=%h exp=000", {rom_addr, SigI, SigQ}); end
        step();
        rst = 1'b1;
        bitq.delete();
        for (int i = 0; i < 400; i++) begin
            step();
            vectors++; if ({done, busy, clk_CarryWave, sym_valid} !== 4'b0000) begin miscompares++; $display("FAIL post_reset k=%0d got=%b exp=0000", k, {done, busy, clk_CarryWave, sym_valid}); end
        end
    endtask

    initial begin
        test_reset();
        test_strobes_preamble();
        test_payload_underrun();
        test_flush_done();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
